// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, RUN/HALTED
// control FSM, and stall/fetch event counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        Halt_Req,
    input  logic        Resume,
    input  logic [31:0] Instr_Mem,
    output logic [31:0] PC_Addr,
    output logic [31:0] PC4_IFID,
    output logic [31:0] Instr_IFID,
    output logic        Valid_IFID,
    output logic        Halted,
    output logic [15:0] Stall_Count,
    output logic [31:0] Fetch_Count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [15:0] stall_q, stall_d;
    logic [31:0] fetch_q, fetch_d;
    logic [31:0] pc_plus4;

    // Adder wraps naturally at 2^32.
    assign pc_plus4 = pc_q + 32'd4;

    // Next-state selection: halt beats branch, branch beats the stall controls.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        stall_d = stall_q;
        fetch_d = fetch_q;

        unique case (state_q)
            RUN: begin
                if (Halt_Req) begin
                    state_d = HALTED;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (Branch_Taken) begin
                    pc_d    = {Branch_Target[31:2], 2'b00};
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else begin
                    if (PCWrite) begin
                        pc_d = pc_plus4;
                    end else if (stall_q != 16'hFFFF) begin
                        stall_d = stall_q + 16'd1;
                    end
                    if (IFIDWrite) begin
                        instr_d = Instr_Mem;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        fetch_d = fetch_q + 32'd1;
                    end
                end
            end
            HALTED: begin
                // Everything frozen; only Resume is observed.
                if (Resume) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State register bank with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            stall_q <= 16'd0;
            fetch_q <= 32'd0;
        end else begin
            // NOTE: non-blocking so all registers update together from pre-edge values.
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            fetch_q <= fetch_d;
        end
    end

    // Outputs come straight from registers; PC_Addr has no input-to-output path.
    assign PC_Addr     = pc_q;
    assign PC4_IFID    = pc4_q;
    assign Instr_IFID  = instr_q;
    assign Valid_IFID  = valid_q;
    assign Halted      = (state_q == HALTED);
    assign Stall_Count = stall_q;
    assign Fetch_Count = fetch_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        Halt_Req;
    logic        Resume;
    logic [31:0] Instr_Mem;
    logic [31:0] PC_Addr;
    logic [31:0] PC4_IFID;
    logic [31:0] Instr_IFID;
    logic        Valid_IFID;
    logic        Halted;
    logic [15:0] Stall_Count;
    logic [31:0] Fetch_Count;

    int tests_run;
    int tests_failed;

    fetch_stage #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .Branch_Taken (Branch_Taken),
        .Branch_Target(Branch_Target),
        .Halt_Req     (Halt_Req),
        .Resume       (Resume),
        .Instr_Mem    (Instr_Mem),
        .PC_Addr      (PC_Addr),
        .PC4_IFID     (PC4_IFID),
        .Instr_IFID   (Instr_IFID),
        .Valid_IFID   (Valid_IFID),
        .Halted       (Halted),
        .Stall_Count  (Stall_Count),
        .Fetch_Count  (Fetch_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pcw, input logic ifw, input logic br,
                         input logic [31:0] tgt, input logic hlt, input logic res,
                         input logic [31:0] instr);
        PCWrite       = pcw;
        IFIDWrite     = ifw;
        Branch_Taken  = br;
        Branch_Target = tgt;
        Halt_Req      = hlt;
        Resume        = res;
        Instr_Mem     = instr;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'hAAAA_AAAA);
        #2;
        tests_run++;
        if (PC_Addr !== RST_PC || Instr_IFID !== NOP || PC4_IFID !== 32'h0 ||
            Valid_IFID !== 1'b0 || Halted !== 1'b0 || Stall_Count !== 16'h0 ||
            Fetch_Count !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_values: pc=%h instr=%h pc4=%h v=%b h=%b sc=%h fc=%h",
                     PC_Addr, Instr_IFID, PC4_IFID, Valid_IFID, Halted, Stall_Count, Fetch_Count);
        end
        tick();
        tests_run++;
        if (PC_Addr !== RST_PC || Valid_IFID !== 1'b0 || Fetch_Count !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_holds_over_edge: pc=%h v=%b fc=%h", PC_Addr, Valid_IFID, Fetch_Count);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h2008_0005);
        tick();
        tests_run++;
        if (PC_Addr !== 32'h4 || Instr_IFID !== 32'h2008_0005 || PC4_IFID !== 32'h4 ||
            Valid_IFID !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_fetch: pc=%h instr=%h pc4=%h v=%b (want 4 20080005 4 1)",
                     PC_Addr, Instr_IFID, PC4_IFID, Valid_IFID);
        end
        tick();
        tick();
        tests_run++;
        if (PC_Addr !== 32'hC || PC4_IFID !== 32'hC || Valid_IFID !== 1'b1 ||
            Fetch_Count !== 32'd3) begin
            tests_failed++;
            $display("FAIL sequential: pc=%h pc4=%h v=%b fc=%0d (want c c 1 3)",
                     PC_Addr, PC4_IFID, Valid_IFID, Fetch_Count);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1111_1111);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        tick();
        tests_run++;
        if (PC_Addr !== 32'h10 || Instr_IFID !== 32'h1111_1111 || Valid_IFID !== 1'b1 ||
            Stall_Count !== 16'd1) begin
            tests_failed++;
            $display("FAIL load_use_stall: pc=%h instr=%h v=%b sc=%0d (want 10 11111111 1 1)",
                     PC_Addr, Instr_IFID, Valid_IFID, Stall_Count);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h2222_2222);
        tick();
        tests_run++;
        if (PC_Addr !== 32'h14 || Instr_IFID !== 32'h2222_2222 || PC4_IFID !== 32'h14 ||
            Fetch_Count !== 32'd5) begin
            tests_failed++;
            $display("FAIL stall_release: pc=%h instr=%h pc4=%h fc=%0d (want 14 22222222 14 5)",
                     PC_Addr, Instr_IFID, PC4_IFID, Fetch_Count);
        end
        // PC held while IF/ID loads.
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h3333_3333);
        tick();
        tests_run++;
        if (PC_Addr !== 32'h14 || Instr_IFID !== 32'h3333_3333 || PC4_IFID !== 32'h18 ||
            Stall_Count !== 16'd2 || Fetch_Count !== 32'd6) begin
            tests_failed++;
            $display("FAIL pc_hold_ifid_load: pc=%h instr=%h pc4=%h sc=%0d fc=%0d (want 14 33333333 18 2 6)",
                     PC_Addr, Instr_IFID, PC4_IFID, Stall_Count, Fetch_Count);
        end
        // PC advances while IF/ID holds.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4444_0000);
        tick();
        tests_run++;
        if (PC_Addr !== 32'h18 || Instr_IFID !== 32'h3333_3333 || PC4_IFID !== 32'h18 ||
            Stall_Count !== 16'd2 || Fetch_Count !== 32'd6) begin
            tests_failed++;
            $display("FAIL pc_adv_ifid_hold: pc=%h instr=%h pc4=%h sc=%0d fc=%0d (want 18 33333333 18 2 6)",
                     PC_Addr, Instr_IFID, PC4_IFID, Stall_Count, Fetch_Count);
        end
    endtask

    task automatic test_branch();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h5555_5555);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 32'h6666_6666);
        tick();
        tests_run++;
        if (PC_Addr !== 32'h100 || Instr_IFID !== NOP || Valid_IFID !== 1'b0 ||
            Stall_Count !== 16'd2 || Fetch_Count !== 32'd8) begin
            tests_failed++;
            $display("FAIL branch_over_stall: pc=%h instr=%h v=%b sc=%0d fc=%0d (want 100 00000013 0 2 8)",
                     PC_Addr, Instr_IFID, Valid_IFID, Stall_Count, Fetch_Count);
        end
    endtask

    task automatic test_halt_resume();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_003C, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h7777_7777);
        tick();
        // Halt has priority over a simultaneous branch.
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h8888_8888);
        tick();
        tests_run++;
        if (Halted !== 1'b1 || Valid_IFID !== 1'b0 || Instr_IFID !== NOP || PC_Addr !== 32'h40 ||
            PC4_IFID !== 32'h40 || Fetch_Count !== 32'd9 || Stall_Count !== 16'd2) begin
            tests_failed++;
            $display("FAIL halt_entry: h=%b v=%b instr=%h pc=%h pc4=%h fc=%0d sc=%0d (want 1 0 00000013 40 40 9 2)",
                     Halted, Valid_IFID, Instr_IFID, PC_Addr, PC4_IFID, Fetch_Count, Stall_Count);
        end
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h9999_9999);
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (Halted !== 1'b1 || PC_Addr !== 32'h40 || Valid_IFID !== 1'b0 ||
                Stall_Count !== 16'd2 || Fetch_Count !== 32'd9) begin
                tests_failed++;
                $display("FAIL halted_hold[%0d]: h=%b pc=%h v=%b sc=%0d fc=%0d (want 1 40 0 2 9)",
                         i, Halted, PC_Addr, Valid_IFID, Stall_Count, Fetch_Count);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA_0001);
        tick();
        tests_run++;
        if (Halted !== 1'b0 || PC_Addr !== 32'h40 || Valid_IFID !== 1'b0) begin
            tests_failed++;
            $display("FAIL resume: h=%b pc=%h v=%b (want 0 40 0)", Halted, PC_Addr, Valid_IFID);
        end
        // Resume left high in RUN has no effect.
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA_0002);
        tick();
        tests_run++;
        if (Halted !== 1'b0 || PC_Addr !== 32'h44 || Instr_IFID !== 32'hAAAA_0002 ||
            PC4_IFID !== 32'h44 || Valid_IFID !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_after_resume: h=%b pc=%h instr=%h pc4=%h v=%b (want 0 44 aaaa0002 44 1)",
                     Halted, PC_Addr, Instr_IFID, PC4_IFID, Valid_IFID);
        end
    endtask

    task automatic test_wrap_saturate();
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0);
        tick();
        tests_run++;
        if (PC_Addr !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL branch_align: pc=%h (want fffffffc)", PC_Addr);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'hBBBB_BBBB);
        tick();
        tests_run++;
        if (PC_Addr !== 32'h0 || PC4_IFID !== 32'h0 || Instr_IFID !== 32'hBBBB_BBBB) begin
            tests_failed++;
            $display("FAIL pc_wrap: pc=%h pc4=%h instr=%h (want 0 0 bbbbbbbb)",
                     PC_Addr, PC4_IFID, Instr_IFID);
        end
        // Counter is at 2 here; 65533 stalls reach the ceiling exactly.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 65532; i++) tick();
        tests_run++;
        if (Stall_Count !== 16'hFFFE) begin
            tests_failed++;
            $display("FAIL stall_pre_sat: sc=%h (want fffe)", Stall_Count);
        end
        for (int i = 0; i < 70000 - 65532; i++) tick();
        tests_run++;
        if (Stall_Count !== 16'hFFFF || PC_Addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL stall_saturate: sc=%h pc=%h (want ffff 0)", Stall_Count, PC_Addr);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'hCCCC_CCCC);
        tick();
        tests_run++;
        if (Halted !== 1'b1 || PC_Addr !== 32'h80) begin
            tests_failed++;
            $display("FAIL halt_at_80: h=%b pc=%h (want 1 80)", Halted, PC_Addr);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (PC_Addr !== RST_PC || Halted !== 1'b0 || Instr_IFID !== NOP || PC4_IFID !== 32'h0 ||
            Valid_IFID !== 1'b0 || Stall_Count !== 16'h0 || Fetch_Count !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset: pc=%h h=%b instr=%h pc4=%h v=%b sc=%h fc=%h",
                     PC_Addr, Halted, Instr_IFID, PC4_IFID, Valid_IFID, Stall_Count, Fetch_Count);
        end
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b0, 1'b1, 32'hDDDD_DDDD);
        tick();
        tick();
        tests_run++;
        if (PC_Addr !== RST_PC || Valid_IFID !== 1'b0 || Fetch_Count !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_override: pc=%h v=%b fc=%h (want 0 0 0)", PC_Addr, Valid_IFID, Fetch_Count);
        end
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'hEEEE_EEEE);
        tick();
        tests_run++;
        if (PC_Addr !== 32'h4 || Instr_IFID !== 32'hEEEE_EEEE || Valid_IFID !== 1'b1 ||
            Fetch_Count !== 32'd1) begin
            tests_failed++;
            $display("FAIL fetch_after_reset: pc=%h instr=%h v=%b fc=%0d (want 4 eeeeeeee 1 1)",
                     PC_Addr, Instr_IFID, Valid_IFID, Fetch_Count);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_halt_resume();
        test_wrap_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have a parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have a parameter NOP_INSTR, default 32'h0000_0000, giving the bubble instruction written into IF/ID on flush.
REQ-003 The block SHALL have clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 The block SHALL have reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have PCWrite, input, 1 bit: 1 = PC may advance; 0 = hold PC (load-use stall).
REQ-006 The block SHALL have IFIDWrite, input, 1 bit: 1 = IF/ID may load; 0 = hold IF/ID contents.
REQ-007 The block SHALL have Branch_Taken, input, 1 bit: a taken branch or jump was resolved in ID this cycle.
REQ-008 The block SHALL have Branch_Target, input, 32 bits: redirect address, valid while Branch_Taken=1.
REQ-009 The block SHALL have Halt_Req, input, 1 bit: the halt opcode was decoded in ID.
REQ-010 The block SHALL have Resume, input, 1 bit: leave the HALTED state.
REQ-011 The block SHALL have Instr_Mem, input, 32 bits: instruction word read combinationally at PC_Addr.
REQ-012 The block SHALL have PC_Addr, output, 32 bits: current PC, driven to instruction memory.
REQ-013 The block SHALL have PC4_IFID, output, 32 bits: registered PC+4 of the instruction held in IF/ID.
REQ-014 The block SHALL have Instr_IFID, output, 32 bits: registered instruction held in IF/ID.
REQ-015 The block SHALL have Valid_IFID, output, 1 bit: 1 = Instr_IFID is a real instruction; 0 = bubble.
REQ-016 The block SHALL have Halted, output, 1 bit: the FSM is in HALTED.
REQ-017 The block SHALL have Stall_Count, output, 16 bits: saturating count of load-use stall cycles.
REQ-018 The block SHALL have Fetch_Count, output, 32 bits: wrapping count of instructions loaded as valid into IF/ID.

Function
REQ-019 The FSM SHALL have exactly two states, RUN and HALTED, and Halted SHALL equal 1 exactly in HALTED.
REQ-020 In RUN, each edge SHALL apply the first matching case in this order:
- Halt_Req=1 -> next state HALTED; hold PC; IF/ID <= {NOP_INSTR, valid 0}; PC4_IFID held.
- Branch_Taken=1 -> PC <= {Branch_Target[31:2],2'b00}; IF/ID <= {NOP_INSTR, valid 0}. This case overrides PCWrite=0 and IFIDWrite=0.
- Otherwise PCWrite and IFIDWrite act independently:
  - PCWrite=1 -> PC <= PC+4.
  - IFIDWrite=1 -> Instr_IFID <= Instr_Mem; PC4_IFID <= PC+4; Valid_IFID <= 1.
  - A signal at 0 holds its register, including Valid_IFID.
REQ-021 In HALTED, PC and IF/ID SHALL hold, and Branch_Taken, PCWrite, IFIDWrite and Halt_Req SHALL be ignored.
REQ-022 In HALTED, Resume=1 SHALL return the FSM to RUN on the next edge, with fetch restarting from the held PC (the address after the halt instruction).
REQ-023 Resume SHALL be ignored in RUN.
REQ-024 PC+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-025 Fetch latency SHALL be one cycle: the word present on Instr_Mem at edge N appears on Instr_IFID after edge N.
REQ-026 Stall_Count SHALL increment by 1 on each edge in RUN where PCWrite=0, Branch_Taken=0 and Halt_Req=0.
REQ-027 Stall_Count SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-028 Fetch_Count SHALL increment by 1 on each edge where IF/ID loads with valid 1, and SHALL wrap at 2^32.
REQ-029 PC_Addr SHALL be the PC register output directly, with no combinational path from any input.

Reset
REQ-030 reset=1 SHALL immediately, independent of clk, set:
- PC = RESET_PC.
- Instr_IFID = NOP_INSTR, PC4_IFID = 0, Valid_IFID = 0.
- FSM = RUN, Halted = 0.
- Stall_Count = 0, Fetch_Count = 0.
REQ-031 Reset asserted mid-stall, mid-branch or in HALTED SHALL override every other input.
REQ-032 The first fetch from RESET_PC SHALL occur on the first edge after reset deasserts.

Verification
REQ-033 Sequential fetch: reset, then 3 edges with PCWrite=IFIDWrite=1 and Instr_Mem=32'h2008_0005 -> PC_Addr=0x0C, PC4_IFID=0x0C, Valid_IFID=1, Fetch_Count=3.
REQ-034 Load-use stall: at PC=0x10, PCWrite=IFIDWrite=0 for 1 edge -> PC_Addr stays 0x10, Instr_IFID unchanged, Stall_Count +1; next normal edge -> PC_Addr=0x14.
REQ-035 Branch over stall: at PC=0x20, Branch_Taken=1, Branch_Target=0x0000_0103, PCWrite=0 -> PC_Addr=0x100, Instr_IFID=NOP_INSTR, Valid_IFID=0, Stall_Count unchanged.
REQ-036 Halt/resume: at PC=0x40, Halt_Req=1 -> Halted=1, Valid_IFID=0, PC_Addr=0x40 held for 5 edges despite Branch_Taken=1; Resume=1 -> Halted=0, next edge PC_Addr=0x44.
REQ-037 Wrap and saturation: force PC=0xFFFF_FFFC and advance -> PC_Addr=0; hold PCWrite=0 for 70000 edges -> Stall_Count=16'hFFFF.
REQ-038 Asynchronous reset: assert reset between clock edges while HALTED at PC=0x80 -> outputs reach reset values before the next edge; Halted=0, PC_Addr=RESET_PC.
